// File: rtl/potion_pkg.sv
// Shared definitions for the potion game flow: state codes and menu colour.
package potion_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_INIT   = 4'd2,
    ST_PLAY   = 4'd3,
    ST_RESULT = 4'd4
  } state_e;

  localparam logic [15:0] MENU_COLOUR = 16'h0000;

  // Largest of three cycle budgets; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/potion_flow_ctrl.sv
// Top-level flow controller for the potion game: sequences the
// IDLE -> LOAD -> INIT -> PLAY -> RESULT rounds, selects the OLED pixel
// source, counts completed rounds and flags INIT timeouts.
module potion_flow_ctrl
  import potion_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES   = 200,
  parameter int unsigned INIT_TIMEOUT  = 1000,
  parameter int unsigned RESULT_CYCLES = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnC,
  input  logic        done_initialize,
  input  logic        potion_ended,
  input  logic [15:0] oled_potion,
  input  logic [15:0] oled_loading,
  output logic [3:0]  state,
  output logic [15:0] oled_data,
  output logic [7:0]  games_played,
  output logic        init_fail
);

  localparam int unsigned MAX_P = max3(LOAD_CYCLES, INIT_TIMEOUT, RESULT_CYCLES);
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       games_q, games_d;
  logic             init_fail_q, init_fail_d;

  // State, phase counter, round count and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      games_q     <= '0;
      init_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      games_q     <= games_d;
      init_fail_q <= init_fail_d;
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_d     = state_q;
    games_d     = games_q;
    init_fail_d = init_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (btnC) begin
          state_d     = ST_LOAD;
          init_fail_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) state_d = ST_LOAD == ST_LOAD ? ST_INIT : ST_INIT;
      end
      ST_INIT: begin
        // Completion takes priority over a coincident timeout.
        if (done_initialize) begin
          state_d = ST_PLAY;
        end else if (cnt_q == INIT_LAST) begin
          state_d     = ST_IDLE;
          init_fail_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (potion_ended) begin
          state_d = ST_RESULT;
          if (games_q != '1) games_d = games_q + 8'd1;
        end
      end
      ST_RESULT: begin
        if (btnC || (cnt_q == RESULT_LAST)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Pixel source selection driven by the registered state.
  always_comb begin
    oled_data = MENU_COLOUR;
    case (state_q)
      ST_IDLE:            oled_data = MENU_COLOUR;
      ST_LOAD, ST_INIT:   oled_data = oled_loading;
      ST_PLAY, ST_RESULT: oled_data = oled_potion;
      default:            oled_data = MENU_COLOUR;
    endcase
  end

  assign state        = state_q;
  assign games_played = games_q;
  assign init_fail    = init_fail_q;

endmodule

// File: tb/tb_potion_flow_ctrl.sv
// Scoreboard bench for potion_flow_ctrl: the driver pushes per-cycle
// expectations from a behavioural model, the monitor pops and compares.
module tb_potion_flow_ctrl;

  localparam int LC = 4;
  localparam int IT = 8;
  localparam int RC = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnC = 1'b0;
  logic        done_initialize = 1'b0;
  logic        potion_ended = 1'b0;
  logic [15:0] oled_potion = '0;
  logic [15:0] oled_loading = '0;
  logic [3:0]  state;
  logic [15:0] oled_data;
  logic [7:0]  games_played;
  logic        init_fail;

  always #5 clk = ~clk;

  potion_flow_ctrl #(
    .LOAD_CYCLES  (LC),
    .INIT_TIMEOUT (IT),
    .RESULT_CYCLES(RC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btnC            (btnC),
    .done_initialize (done_initialize),
    .potion_ended    (potion_ended),
    .oled_potion     (oled_potion),
    .oled_loading    (oled_loading),
    .state           (state),
    .oled_data       (oled_data),
    .games_played    (games_played),
    .init_fail       (init_fail)
  );

  typedef struct {
    logic [3:0]  st;
    logic [15:0] oled;
    logic [7:0]  gp;
    logic        fail;
  } exp_t;

  exp_t sbq[$];
  int   trace[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: current phase, cycles spent in it, rounds, flag.
  int m_st   = 0;
  int m_age  = 0;
  int m_games = 0;
  bit m_fail = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_advance(input bit btn, input bit done, input bit ended);
    int nxt;
    nxt = m_st;
    if (m_st == 0) begin
      if (btn) begin nxt = 1; m_fail = 1'b0; end
    end else if (m_st == 1) begin
      if (m_age + 1 == LC) nxt = 2;
    end else if (m_st == 2) begin
      if (done) nxt = 3;
      else if (m_age + 1 == IT) begin nxt = 0; m_fail = 1'b1; end
    end else if (m_st == 3) begin
      if (ended) begin
        nxt = 4;
        m_games = (m_games >= 255) ? 255 : m_games + 1;
      end
    end else begin
      if (btn || (m_age + 1 == RC)) nxt = 0;
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  // One clock cycle of stimulus; records what the DUT must show this cycle.
  task automatic cycle(input bit rst, input bit btn, input bit done, input bit ended);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n           = rst;
    btnC            = btn;
    done_initialize = done;
    potion_ended    = ended;
    oled_potion     = 16'($urandom);
    oled_loading    = 16'($urandom);
    if (!rst) begin
      m_st = 0; m_age = 0; m_games = 0; m_fail = 1'b0;
    end
    e.st   = 4'(m_st);
    e.gp   = 8'(m_games);
    e.fail = m_fail;
    e.oled = (m_st == 0) ? 16'h0000 : ((m_st <= 2) ? oled_loading : oled_potion);
    sbq.push_back(e);
    if (rst) model_advance(btn, done, ended);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic to_idle();
    int n;
    n = 0;
    while (m_st != 0 && n < 100) begin
      cycle(1'b1, m_st == 4, m_st == 2, m_st == 3);
      n++;
    end
    if (m_st != 0) begin
      tests++; fails++;
      $display("FAIL to_idle: model state %0d expected 0 after %0d cycles", m_st, n);
    end
  endtask

  function automatic int count_state(input int s);
    int c;
    c = 0;
    foreach (trace[i]) if (trace[i] == s) c++;
    return c;
  endfunction

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("oled_data", 32'(oled_data), 32'(e.oled));
      chk("games_played", 32'(games_played), 32'(e.gp));
      chk("init_fail", 32'(init_fail), 32'(e.fail));
      trace.push_back(int'(state));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_seq[$];
    int bad;

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Full flow with exact phase lengths.
    settle(); trace.delete();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (LC) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (RC) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    exp_seq.delete();
    exp_seq.push_back(0);
    repeat (4)  exp_seq.push_back(1);
    repeat (3)  exp_seq.push_back(2);
    repeat (10) exp_seq.push_back(3);
    repeat (5)  exp_seq.push_back(4);
    exp_seq.push_back(0);
    chk("flow_len", 32'(trace.size()), 32'(exp_seq.size()));
    bad = 0;
    foreach (exp_seq[i]) if (i >= trace.size() || trace[i] != exp_seq[i]) bad++;
    chk("flow_seq", 32'(bad), 32'd0);
    chk("flow_games", 32'(games_played), 32'd1);

    // INIT timeout, then a fresh btnC clears the flag.
    trace.delete();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (LC + IT) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("timeout_init_cycles", 32'(count_state(2)), 32'd8);
    chk("timeout_state", 32'(state), 32'd0);
    chk("timeout_flag", 32'(init_fail), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("restart_flag", 32'(init_fail), 32'd0);
    chk("restart_state", 32'(state), 32'd1);
    to_idle();

    // Tie: completion on the last INIT cycle wins.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (LC + IT - 1) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("tie_state", 32'(state), 32'd3);
    chk("tie_flag", 32'(init_fail), 32'd0);
    to_idle();

    // Ignored inputs, and btnC early in RESULT.
    settle(); trace.delete();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ign_load_cycles", 32'(count_state(1)), 32'd4);
    chk("ign_init_cycles", 32'(count_state(2)), 32'd3);
    chk("ign_play_cycles", 32'(count_state(3)), 32'd4);
    chk("ign_result_cycles", 32'(count_state(4)), 32'd2);
    chk("ign_end_state", 32'(state), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'b1, ($urandom_range(3) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0));
    to_idle();

    // Saturation of the round counter.
    for (int r = 0; r < 256; r++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      to_idle();
    end
    settle();
    chk("saturate", 32'(games_played), 32'd255);

    // Reset in the middle of PLAY, observed before any clock edge.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (LC) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_games", 32'(games_played), 32'd0);
    chk("rst_async_oled", 32'(oled_data), 32'h0000);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_stays_idle", 32'(state), 32'd0);
    chk("rst_no_count", 32'(games_played), 32'd0);

    settle();
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
